// File: rtl/gelato_register_file_banked_pkg.sv
// Shared defaults, storage types and helpers for the banked vector register file.
// Bypass forwarding is selected at build time with GELATO_RF_BYPASS_EN.
package gelato_register_file_banked_pkg;

  localparam int DEF_WARP_NUM   = 8;
  localparam int DEF_REG_NUM    = 32;
  localparam int DEF_BANK_NUM   = 4;
  localparam int DEF_THREAD_NUM = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_READ_PORTS = 3;

  localparam int DEF_WARP_W = $clog2(DEF_WARP_NUM);
  localparam int DEF_REG_W  = $clog2(DEF_REG_NUM);

  typedef logic [DEF_THREAD_NUM*DEF_DATA_WIDTH-1:0] warp_reg_t;
  typedef logic [DEF_WARP_W-1:0]                    warp_idx_t;
  typedef logic [DEF_REG_W-1:0]                     reg_idx_t;

  typedef struct packed {
    warp_idx_t warp;
    reg_idx_t  reg_idx;
  } rf_read_req_t;

  typedef struct packed {
    warp_idx_t                 warp;
    reg_idx_t                  reg_idx;
    logic [DEF_THREAD_NUM-1:0] mask;
    warp_reg_t                 data;
  } rf_write_req_t;

  // Saturating add used by the conflict counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {9'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/gelato_register_bank_sram.sv
// One register bank: 1R1W, registered read, lane-masked write.
// With GELATO_RF_BYPASS_EN a same-row write is forwarded into the read word.
module gelato_register_bank_sram #(
  parameter int DEPTH = 64,
  parameter int ROW_W = 6,
  parameter int LANES = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rd_en,
  input  logic [ROW_W-1:0]    i_rd_row,
  output logic [LANES*DW-1:0] o_rd_data,
  input  logic                i_wr_en,
  input  logic [ROW_W-1:0]    i_wr_row,
  input  logic [LANES-1:0]    i_wr_mask,
  input  logic [LANES*DW-1:0] i_wr_data
);

  logic [LANES*DW-1:0] r_mem [DEPTH];
  logic [LANES*DW-1:0] r_q;
  logic [LANES*DW-1:0] w_rd_word;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int t = 0; t < LANES; t++) begin
        if (i_wr_mask[t]) r_mem[i_wr_row][t*DW +: DW] <= i_wr_data[t*DW +: DW];
      end
    end
  end

  always_comb begin
    w_rd_word = r_mem[i_rd_row];
`ifdef GELATO_RF_BYPASS_EN
    for (int t = 0; t < LANES; t++) begin
      if (i_wr_en && i_wr_mask[t] && (i_wr_row == i_rd_row))
        w_rd_word[t*DW +: DW] = i_wr_data[t*DW +: DW];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= '0;
    else if (i_rd_en) r_q <= w_rd_word;
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/gelato_register_file_banked.sv
// Banked per-warp vector register file: READ_PORTS arbitrated read ports, one writeback port.
// Optional same-cycle write-to-read forwarding under GELATO_RF_BYPASS_EN.
module gelato_register_file_banked
  import gelato_register_file_banked_pkg::*;
#(
  parameter int WARP_NUM   = DEF_WARP_NUM,
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int BANK_NUM   = DEF_BANK_NUM,
  parameter int THREAD_NUM = DEF_THREAD_NUM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  localparam int WARP_W    = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1,
  localparam int REG_W     = $clog2(REG_NUM),
  localparam int LANE_BITS = THREAD_NUM * DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  input  logic [READ_PORTS-1:0]          rd_valid,
  output logic [READ_PORTS-1:0]          rd_ready,
  input  logic [READ_PORTS*WARP_W-1:0]   rd_warp,
  input  logic [READ_PORTS*REG_W-1:0]    rd_reg,
  output logic [READ_PORTS-1:0]          rd_data_valid,
  output logic [READ_PORTS*LANE_BITS-1:0] rd_data,
  input  logic                           wr_valid,
  input  logic [WARP_W-1:0]              wr_warp,
  input  logic [REG_W-1:0]               wr_reg,
  input  logic [THREAD_NUM-1:0]          wr_mask,
  input  logic [LANE_BITS-1:0]           wr_data,
  output logic [15:0]                    conflict_cnt
);

  // Handshake: a read port is accepted when rdy & rd_valid & granted; a refused
  // port must hold its request. Data returns with rd_data_valid one cycle later.
  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int ROW_W  = WARP_W + REG_W - BANK_W;
  localparam int DEPTH  = WARP_NUM * REG_NUM / BANK_NUM;

  logic [READ_PORTS-1:0][BANK_W-1:0]    w_bank;
  logic [READ_PORTS-1:0][ROW_W-1:0]     w_row;
  logic [READ_PORTS-1:0]                w_granted;
  logic [READ_PORTS-1:0]                w_refused;
  logic [7:0]                           w_refused_n;
  logic [BANK_NUM-1:0]                  w_bank_rd_en;
  logic [BANK_NUM-1:0][ROW_W-1:0]       w_bank_rd_row;
  logic [BANK_NUM-1:0]                  w_bank_wr_en;
  logic [BANK_NUM-1:0][LANE_BITS-1:0]   w_bank_q;
  logic [READ_PORTS-1:0][LANE_BITS-1:0] w_rd_data;
  logic [BANK_W-1:0]                    w_wr_bank;
  logic [ROW_W-1:0]                     w_wr_row;

  logic [READ_PORTS-1:0]                r_valid;
  logic [READ_PORTS-1:0][BANK_W-1:0]    r_sel;
  logic [READ_PORTS-1:0][LANE_BITS-1:0] r_hold;
  logic [15:0]                          r_cnt;

  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      w_bank[i] = rd_reg[i*REG_W +: BANK_W];
      w_row[i]  = {rd_warp[i*WARP_W +: WARP_W], rd_reg[i*REG_W+BANK_W +: REG_W-BANK_W]};
    end
  end

  // Fixed priority per bank: the lowest-index valid port on a bank wins it.
  always_comb begin
    w_granted = '1;
    for (int i = 1; i < READ_PORTS; i++) begin
      for (int j = 0; j < i; j++) begin
        if (rd_valid[j] && (w_bank[j] == w_bank[i])) w_granted[i] = 1'b0;
      end
    end
  end

  assign rd_ready  = {READ_PORTS{rdy}} & rd_valid & w_granted;
  assign w_refused = {READ_PORTS{rdy}} & rd_valid & ~w_granted;

  always_comb begin
    w_refused_n = '0;
    for (int i = 0; i < READ_PORTS; i++) w_refused_n = w_refused_n + 8'(w_refused[i]);
  end

  // At most one accepted port per bank, so the route is unambiguous.
  always_comb begin
    w_bank_rd_en  = '0;
    w_bank_rd_row = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int i = 0; i < READ_PORTS; i++) begin
        if (rd_ready[i] && (w_bank[i] == BANK_W'(b))) begin
          w_bank_rd_en[b]  = 1'b1;
          w_bank_rd_row[b] = w_row[i];
        end
      end
    end
  end

  assign w_wr_bank = wr_reg[BANK_W-1:0];
  assign w_wr_row  = {wr_warp, wr_reg[REG_W-1:BANK_W]};

  always_comb begin
    w_bank_wr_en = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      w_bank_wr_en[b] = rdy && wr_valid && (w_wr_bank == BANK_W'(b));
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    gelato_register_bank_sram #(
      .DEPTH (DEPTH),
      .ROW_W (ROW_W),
      .LANES (THREAD_NUM),
      .DW    (DATA_WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_en   (w_bank_rd_en[b]),
      .i_rd_row  (w_bank_rd_row[b]),
      .o_rd_data (w_bank_q[b]),
      .i_wr_en   (w_bank_wr_en[b]),
      .i_wr_row  (w_wr_row),
      .i_wr_mask (wr_mask),
      .i_wr_data (wr_data)
    );
  end

  // Banks only advance on a read, so a valid port's bank word is stable until
  // the same edge that clears or refreshes its valid bit.
  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      w_rd_data[i] = r_valid[i] ? w_bank_q[r_sel[i]] : r_hold[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else if (rdy) begin
      r_valid <= rd_ready;
      r_sel   <= w_bank;
      r_hold  <= w_rd_data;
      r_cnt   <= sat_add16(r_cnt, w_refused_n);
    end
  end

  assign rd_data_valid = r_valid;
  assign rd_data       = w_rd_data;
  assign conflict_cnt  = r_cnt;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_chk
    a_warp_range: assert property (@(posedge clk) disable iff (!rst_n)
      (rdy && rd_valid[i]) |-> (32'(rd_warp[i*WARP_W +: WARP_W]) < WARP_NUM));
  end

endmodule

// File: tb/tb_gelato_register_file_banked.sv
// Directed bench for gelato_register_file_banked with hand-computed expectations.
// Expects the forwarded value on same-cycle read/write when GELATO_RF_BYPASS_EN is defined.
module tb_gelato_register_file_banked;

  logic          clk;
  logic          rst_n;
  logic          rdy;
  logic [2:0]    rd_valid;
  logic [2:0]    rd_ready;
  logic [8:0]    rd_warp;
  logic [14:0]   rd_reg;
  logic [2:0]    rd_data_valid;
  logic [3071:0] rd_data;
  logic          wr_valid;
  logic [2:0]    wr_warp;
  logic [4:0]    wr_reg;
  logic [31:0]   wr_mask;
  logic [1023:0] wr_data;
  logic [15:0]   conflict_cnt;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  gelato_register_file_banked dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_warp       (rd_warp),
    .rd_reg        (rd_reg),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .wr_valid      (wr_valid),
    .wr_warp       (wr_warp),
    .wr_reg        (wr_reg),
    .wr_mask       (wr_mask),
    .wr_data       (wr_data),
    .conflict_cnt  (conflict_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int p, input int t);
    return rd_data[(p*32+t)*32 +: 32];
  endfunction

  // driver tasks
  task automatic set_rd(input int p, input logic [2:0] w, input logic [4:0] r);
    rd_warp[p*3 +: 3] = w;
    rd_reg[p*5 +: 5]  = r;
  endtask

  task automatic load_wr(input logic [2:0] w, input logic [4:0] r, input logic [31:0] m,
                         input logic [31:0] base, input bit add_lane);
    wr_valid = 1'b1;
    wr_warp  = w;
    wr_reg   = r;
    wr_mask  = m;
    for (int t = 0; t < 32; t++) wr_data[t*32 +: 32] = base + (add_lane ? 32'(t) : 32'd0);
  endtask

  task automatic write_fill(input logic [2:0] w, input logic [4:0] r, input logic [31:0] m,
                            input logic [31:0] base, input bit add_lane);
    load_wr(w, r, m, base, add_lane);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [2:0] m, input logic [2:0] exp_rdy);
    rd_valid = m;
    #1;
    check({tag, "_rdy"}, 32'(rd_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    rd_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rdy      = 1'b0;
    rd_valid = '0;
    rd_warp  = '0;
    rd_reg   = '0;
    wr_valid = 1'b0;
    wr_warp  = '0;
    wr_reg   = '0;
    wr_mask  = '0;
    wr_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rd_data_valid), 32'd0);
    check("rst_cnt",   32'(conflict_cnt), 32'd0);
    check("rst_data",  lane(0, 0), 32'd0);
    check("rst_ready", 32'(rd_ready), 32'd0);
    rst_n = 1'b1;
    rdy   = 1'b1;
    @(posedge clk); #1;

    // basic write then read
    write_fill(3'd2, 5'd5, '1, 32'hA5A5_0000, 1'b1);
    set_rd(0, 3'd2, 5'd5);
    issue("basic", 3'b001, 3'b001);
    check("basic_valid", 32'(rd_data_valid), 32'h1);
    check("basic_l7", lane(0, 7), 32'hA5A5_0007);
    check("basic_l0", lane(0, 0), 32'hA5A5_0000);
    @(posedge clk); #1;
    check("idle_valid", 32'(rd_data_valid), 32'h0);
    check("idle_hold", lane(0, 7), 32'hA5A5_0007);

    // bank-1 conflict across all three ports
    write_fill(3'd2, 5'd1, '1, 32'h0000_0011, 1'b0);
    write_fill(3'd2, 5'd9, '1, 32'h0000_0099, 1'b0);
    write_fill(3'd2, 5'd0, '1, 32'h0000_C000, 1'b0);
    write_fill(3'd2, 5'd2, '1, 32'h0000_C002, 1'b0);
    set_rd(0, 3'd2, 5'd1);
    set_rd(1, 3'd2, 5'd5);
    set_rd(2, 3'd2, 5'd9);
    issue("cf0", 3'b111, 3'b001);
    check("cf0_cnt", 32'(conflict_cnt), 32'd2);
    check("cf0_valid", 32'(rd_data_valid), 32'h1);
    check("cf0_data", lane(0, 0), 32'h0000_0011);
    issue("cf1", 3'b110, 3'b010);
    check("cf1_cnt", 32'(conflict_cnt), 32'd3);
    check("cf1_valid", 32'(rd_data_valid), 32'h2);
    check("cf1_data", lane(1, 3), 32'hA5A5_0003);
    issue("cf2", 3'b100, 3'b100);
    check("cf2_cnt", 32'(conflict_cnt), 32'd3);
    check("cf2_valid", 32'(rd_data_valid), 32'h4);
    check("cf2_data", lane(2, 31), 32'h0000_0099);

    // distinct banks, all granted
    set_rd(0, 3'd2, 5'd0);
    set_rd(1, 3'd2, 5'd1);
    set_rd(2, 3'd2, 5'd2);
    issue("par", 3'b111, 3'b111);
    exp_q.push_back(32'h0000_C000);
    exp_q.push_back(32'h0000_0011);
    exp_q.push_back(32'h0000_C002);
    for (int p = 0; p < 3; p++) check($sformatf("par_p%0d", p), lane(p, 4), exp_q.pop_front());
    check("par_valid", 32'(rd_data_valid), 32'h7);
    check("par_cnt", 32'(conflict_cnt), 32'd3);

    // masked write
    write_fill(3'd1, 5'd3, '1, 32'h2, 1'b0);
    write_fill(3'd1, 5'd3, 32'h0000_FFFF, 32'h1, 1'b0);
    set_rd(1, 3'd1, 5'd3);
    issue("mask", 3'b010, 3'b010);
    check("mask_l0",  lane(1, 0),  32'h1);
    check("mask_l15", lane(1, 15), 32'h1);
    check("mask_l16", lane(1, 16), 32'h2);
    check("mask_l31", lane(1, 31), 32'h2);

    // same-cycle write and read of one register
    write_fill(3'd3, 5'd7, '1, 32'h0, 1'b0);
    load_wr(3'd3, 5'd7, '1, 32'h0000_DEAD, 1'b0);
    set_rd(0, 3'd3, 5'd7);
    issue("rw", 3'b001, 3'b001);
    wr_valid = 1'b0;
`ifdef GELATO_RF_BYPASS_EN
    check("rw_same", lane(0, 0), 32'h0000_DEAD);
`else
    check("rw_same", lane(0, 0), 32'h0);
`endif
    issue("rw_after", 3'b001, 3'b001);
    check("rw_after_data", lane(0, 9), 32'h0000_DEAD);

    // rdy low freezes everything, including a pending valid
    rdy = 1'b0;
    set_rd(0, 3'd2, 5'd1);
    set_rd(1, 3'd2, 5'd5);
    set_rd(2, 3'd2, 5'd9);
    rd_valid = 3'b111;
    load_wr(3'd2, 5'd5, '1, 32'hFFFF_FFFF, 1'b0);
    #1;
    check("frz_rdy", 32'(rd_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("frz_valid%0d", c), 32'(rd_data_valid), 32'h1);
      check($sformatf("frz_data%0d", c), lane(0, 0), 32'h0000_DEAD);
      check($sformatf("frz_cnt%0d", c), 32'(conflict_cnt), 32'd3);
    end
    rdy      = 1'b1;
    rd_valid = '0;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    check("unfrz_valid", 32'(rd_data_valid), 32'h0);
    set_rd(0, 3'd2, 5'd5);
    issue("unfrz", 3'b001, 3'b001);
    check("unfrz_data", lane(0, 7), 32'hA5A5_0007);

    // reset while a read is in flight
    set_rd(0, 3'd2, 5'd0);
    issue("rstmid", 3'b001, 3'b001);
    rd_valid = 3'b001;
    rst_n    = 1'b0;
    #1;
    check("rstmid_valid", 32'(rd_data_valid), 32'h0);
    check("rstmid_cnt",   32'(conflict_cnt), 32'd0);
    check("rstmid_data",  lane(0, 0), 32'h0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rd_valid = '0;
    @(posedge clk); #1;
    check("rstpost_valid", 32'(rd_data_valid), 32'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_register_file_banked.md
Name: gelato_register_file_banked

Overview:
- Parametrised successor to the single-bank register storage.
- Holds per-warp vector registers split across BANK_NUM independent single-read/single-write banks.
- Serves READ_PORTS operand-collector read requests plus one writeback port, with per-bank conflict arbitration and a registered 1-cycle read pipeline.
- Sits between issue/operand collection and the execution units.

Parameters:
- WARP_NUM, 8, number of warps; warp index width WARP_W = $clog2(WARP_NUM).
- REG_NUM, 32, architectural registers per warp (power of 2); register index width REG_W = $clog2(REG_NUM).
- BANK_NUM, 4, banks (power of 2, <= REG_NUM); bank = reg_num[$clog2(BANK_NUM)-1:0].
- THREAD_NUM, 32, lanes per warp register.
- DATA_WIDTH, 32, bits per lane.
- READ_PORTS, 3, independent read request ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; low freezes all state.
- rd_valid  in  READ_PORTS  per-port read request.
- rd_ready  out  READ_PORTS  per-port request accepted this cycle.
- rd_warp  in  READ_PORTS*WARP_W  warp index per port.
- rd_reg  in  READ_PORTS*REG_W  register index per port.
- rd_data_valid  out  READ_PORTS  read data valid, one cycle after acceptance.
- rd_data  out  READ_PORTS*THREAD_NUM*DATA_WIDTH  read data per port.
- wr_valid  in  1  writeback request; always accepted when rdy=1.
- wr_warp  in  WARP_W  write warp index.
- wr_reg  in  REG_W  write register index.
- wr_mask  in  THREAD_NUM  per-lane write enable.
- wr_data  in  THREAD_NUM*DATA_WIDTH  write data.
- conflict_cnt  out  16  saturating count of read requests refused due to bank conflict.

Behaviour:
- Reset (async, rst_n=0): rd_data_valid=0, rd_data=0, conflict_cnt=0, internal pipeline regs cleared.
  - Storage contents are not reset; reading a never-written register returns X in simulation.
  - Reset asserted mid-operation discards in-flight reads; no rd_data_valid pulse follows.
- Bank mapping: bank b = rd_reg[log2(BANK_NUM)-1:0]; row within bank = {warp, reg >> log2(BANK_NUM)}.
- Arbitration (combinational, per cycle, per bank):
  - Among valid read ports targeting the same bank, the lowest port index wins.
  - Losers get rd_ready=0 and must hold their request.
  - Ports on distinct banks are all granted.
  - rd_ready[i] = rdy & rd_valid[i] & granted[i].
- Write vs read: the write always proceeds; it does not consume a read slot, since each bank has a separate write port.
- Read latency: a request accepted at edge N gives rd_data_valid=1 and rd_data during cycle N+1. rd_data_valid is low in any cycle with no acceptance the previous cycle. rd_data holds its last value when not valid.
- Write: when rdy & wr_valid at an edge, lanes with wr_mask[t]=1 are updated; other lanes are unchanged. wr_mask=0 is a no-op.
- Same-cycle read and write to the same {warp,reg}, without bypass: the read returns the pre-write value.
- conflict_cnt increments by the number of refused valid ports per cycle (only when rdy=1) and saturates at 16'hFFFF.
- rdy=0: no acceptance (rd_ready=0), no write, counter holds, rd_data_valid/rd_data hold.
- Out-of-range warp index (WARP_NUM not a power of 2): the request is accepted but the data is undefined; an SVA assertion flags it.

Optional Feature:
- GELATO_RF_BYPASS_EN defined: same-cycle write to the same {warp,reg} as an accepted read forwards the masked wr_data lanes into the read result. Unmasked lanes come from storage. The read sees the post-write value.
- Not defined: no forwarding; read returns the old value, as above.

Decomposition:
- gelato_types package: warp_reg_t (THREAD_NUM x DATA_WIDTH vector), warp_idx_t, reg_idx_t, rf_read_req_t {warp, reg}, rf_write_req_t {warp, reg, mask, data}.
- gelato_macros.svh: GELATO_RF_BYPASS_EN default and the BANK_SEL helper macro.
- Sub-module gelato_register_bank_sram: one bank with 1R1W, registered read, lane-masked write, depth WARP_NUM*REG_NUM/BANK_NUM. Instantiated BANK_NUM times via generate.

Test Plan:
- Write warp2/reg5 with data all lanes 32'hA5A5_0000+lane, mask all ones; next cycle read port0 -> after 1 cycle rd_data_valid[0]=1, lane 7 = 32'hA5A5_0007.
- Ports 0,1,2 read regs 1,5,9 (all bank 1) same cycle -> rd_ready=3'b001, conflict_cnt+=2. Requests held -> port1 granted next cycle, then port2. conflict_cnt=3 total.
- Ports read regs 0,1,2 (banks 0,1,2) -> rd_ready=3'b111, three valid results next cycle, conflict_cnt unchanged.
- Masked write, mask=32'h0000_FFFF, data=all 32'h1 over prior all 32'h2 -> readback lanes 0-15 = 1, lanes 16-31 = 2.
- Same-cycle write 32'hDEAD and read of the same warp/reg, prior 32'h0 -> returns 32'h0 without GELATO_RF_BYPASS_EN, 32'hDEAD with it.
- rdy=0 for 3 cycles with requests and a write asserted -> rd_ready=0, storage unchanged, outputs held. Assert rst_n=0 mid-read -> rd_data_valid=0 immediately, conflict_cnt=0.
